layer6_out_pack: RTL and testbench

Downstream stage of the Layer6 convolution/ReLU block. It consumes the 8-bit `reluRes_V_V` AXI-Stream, packs `PACK` consecutive activations into one 32-bit word and drives it to the output DMA stream. It asserts TLAST/TKEEP at each frame boundary so the DMA can close the transfer. A 2-entry output buffer decouples DMA back-pressure from the Layer6 PE.

---
 rtl/layer6_pkg.sv | 14 +
 rtl/stream_fifo2.sv | 66 ++++++
 rtl/layer6_out_pack.sv | 116 +++++++++++
 tb/tb_layer6_out_pack.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer6_pkg.sv
// Shared types and constants for the Layer6 output stages.
package layer6_pkg;

  localparam int unsigned L6_ACT_W     = 8;
  localparam int unsigned L6_PACK      = 4;
  localparam int unsigned L6_FRAME_LEN = 200704;

  typedef struct packed {
    logic [L6_ACT_W*L6_PACK-1:0] data;
    logic [L6_PACK-1:0]          keep;
    logic                        last;
  } l6_word_t;

endpackage

// File: rtl/stream_fifo2.sv
// Generic 2-entry valid/ready FIFO with registered outputs.
// Input ready depends only on occupancy, never on the output ready.
module stream_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data_i;
        else               tail_d = in_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // Clear the head when draining to empty so idle outputs read as zero.
        head_d = (cnt_q == 2'd2) ? tail_q : '0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/layer6_out_pack.sv
// Packs PACK activations per output word, marks frame ends with TLAST/TKEEP
// and buffers two words to decouple DMA back-pressure from the Layer6 PE.
module layer6_out_pack
  import layer6_pkg::*;
#(
  parameter int unsigned DWIDTH_IN = L6_ACT_W,
  parameter int unsigned PACK      = L6_PACK,
  parameter int unsigned FRAME_LEN = L6_FRAME_LEN,
  parameter int unsigned CNT_W     = 20
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [DWIDTH_IN-1:0]      reluRes_V_V_TDATA,
  input  logic                      reluRes_V_V_TVALID,
  output logic                      reluRes_V_V_TREADY,
  output logic [DWIDTH_IN*PACK-1:0] OutDMA_V_V_TDATA,
  output logic [PACK-1:0]           OutDMA_V_V_TKEEP,
  output logic                      OutDMA_V_V_TLAST,
  output logic                      OutDMA_V_V_TVALID,
  input  logic                      OutDMA_V_V_TREADY,
  output logic                      FrameDone
);

  localparam int unsigned OutW  = DWIDTH_IN * PACK;
  localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;

  logic             rst_n_q;
  logic [LaneW-1:0] lane_q, lane_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [OutW-1:0]  data_q, data_d, pack_data;
  logic [PACK-1:0]  keep_q, keep_d, pack_keep;
  logic             frame_done_q;
  logic             in_accept, frame_end, word_done, fifo_ready, out_valid;
  l6_word_t         push_word, head_word;

  // Ready is held low for the first cycle after reset release.
  assign reluRes_V_V_TREADY = rst_n_q && fifo_ready;
  assign in_accept          = reluRes_V_V_TVALID && reluRes_V_V_TREADY;
  assign frame_end          = (act_q == CNT_W'(FRAME_LEN - 1));
  assign word_done          = (lane_q == LaneW'(PACK - 1)) || frame_end;

  always_comb begin
    pack_data = data_q;
    pack_keep = keep_q;
    for (int i = 0; i < PACK; i++) begin
      if (lane_q == LaneW'(i)) begin
        pack_data[i*DWIDTH_IN +: DWIDTH_IN] = reluRes_V_V_TDATA;
        pack_keep[i]                        = 1'b1;
      end
    end
  end

  always_comb begin
    lane_d = lane_q;
    act_d  = act_q;
    data_d = data_q;
    keep_d = keep_q;
    if (in_accept) begin
      act_d = frame_end ? '0 : act_q + CNT_W'(1);
      if (word_done) begin
        lane_d = '0;
        data_d = '0;
        keep_d = '0;
      end else begin
        lane_d = lane_q + LaneW'(1);
        data_d = pack_data;
        keep_d = pack_keep;
      end
    end
  end

  always_comb begin
    push_word      = '0;
    push_word.data = pack_data;
    push_word.keep = pack_keep;
    push_word.last = frame_end;
  end

  stream_fifo2 #(
    .Width($bits(l6_word_t))
  ) u_out_fifo (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .in_data_i  (push_word),
    .in_valid_i (in_accept && word_done),
    .in_ready_o (fifo_ready),
    .out_data_o (head_word),
    .out_valid_o(out_valid),
    .out_ready_i(OutDMA_V_V_TREADY)
  );

  assign OutDMA_V_V_TDATA  = head_word.data;
  assign OutDMA_V_V_TKEEP  = head_word.keep;
  assign OutDMA_V_V_TLAST  = head_word.last;
  assign OutDMA_V_V_TVALID = out_valid;
  assign FrameDone         = frame_done_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rst_n_q      <= 1'b0;
      lane_q       <= '0;
      act_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rst_n_q      <= 1'b1;
      lane_q       <= lane_d;
      act_q        <= act_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      frame_done_q <= out_valid && OutDMA_V_V_TREADY && head_word.last;
    end
  end

endmodule

// File: tb/tb_layer6_out_pack.sv
// Bench for layer6_out_pack: three instances (frame lengths 8, 6, 1) checked against
// a byte-list scoreboard plus directed tables and hand-written corner sequences.
module tb_layer6_out_pack;
  import layer6_pkg::*;

  localparam int NDUT = 3;

  function automatic int fl(input int k);
    case (k)
      0:       return 8;
      1:       return 6;
      default: return 1;
    endcase
  endfunction

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [7:0]  in_data  [NDUT];
  logic        in_valid [NDUT];
  logic        s_ready  [NDUT];
  logic [31:0] o_data   [NDUT];
  logic [3:0]  o_keep   [NDUT];
  logic        o_last   [NDUT];
  logic        o_valid  [NDUT];
  logic        dma_ready[NDUT];
  logic        o_fd     [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    layer6_out_pack #(
      .DWIDTH_IN(8),
      .PACK     (4),
      .FRAME_LEN((k == 0) ? 8 : ((k == 1) ? 6 : 1)),
      .CNT_W    (20)
    ) u_dut (
      .ap_clk            (ap_clk),
      .ap_rst_n          (ap_rst_n),
      .reluRes_V_V_TDATA (in_data[k]),
      .reluRes_V_V_TVALID(in_valid[k]),
      .reluRes_V_V_TREADY(s_ready[k]),
      .OutDMA_V_V_TDATA  (o_data[k]),
      .OutDMA_V_V_TKEEP  (o_keep[k]),
      .OutDMA_V_V_TLAST  (o_last[k]),
      .OutDMA_V_V_TVALID (o_valid[k]),
      .OutDMA_V_V_TREADY (dma_ready[k]),
      .FrameDone         (o_fd[k])
    );
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected words built from the accepted byte stream.
  l6_word_t   exp_q  [NDUT][64];
  int         exp_wr [NDUT];
  int         exp_rd [NDUT];
  logic [7:0] m_bytes[NDUT][4];
  int         m_n    [NDUT];
  int         m_pos  [NDUT];
  bit         fd_exp [NDUT];
  bit         hold   [NDUT];
  l6_word_t   held   [NDUT];
  l6_word_t   log_w  [NDUT][128];
  int         log_n  [NDUT];
  int         last_cnt[NDUT];
  int         fd_cnt [NDUT];
  bit         rnd_done;

  typedef struct {
    int          dut;
    logic [7:0]  first;
    int          n;
    int          n_fd;
    logic [31:0] w0, w1;
    logic [3:0]  k0, k1;
    logic        l0, l1;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input int k, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h", name, k, got, exp);
    end
  endtask

  task automatic model_push(input int k, input logic [7:0] b);
    l6_word_t e;
    m_bytes[k][m_n[k]] = b;
    m_n[k]++;
    m_pos[k]++;
    if (m_n[k] == 4 || m_pos[k] == fl(k)) begin
      e = '0;
      for (int i = 0; i < m_n[k]; i++) e.data[8*i +: 8] = m_bytes[k][i];
      e.keep = 4'((1 << m_n[k]) - 1);
      e.last = (m_pos[k] == fl(k));
      exp_q[k][exp_wr[k] % 64] = e;
      exp_wr[k]++;
      m_n[k] = 0;
      if (e.last) m_pos[k] = 0;
    end
  endtask

  task automatic mon_dut(input int k);
    l6_word_t w;
    bit       xfer;
    w      = '0;
    w.data = o_data[k];
    w.keep = o_keep[k];
    w.last = o_last[k];
    if (o_fd[k]) fd_cnt[k]++;
    if (fd_exp[k] || o_fd[k]) chk("frame_done", k, 64'(o_fd[k]), 64'(fd_exp[k]));
    if (hold[k]) begin
      chk("hold_valid", k, 64'(o_valid[k]), 64'(1));
      chk("hold_word", k, 64'(w), 64'(held[k]));
    end
    xfer      = o_valid[k] && dma_ready[k];
    fd_exp[k] = 1'b0;
    hold[k]   = 1'b0;
    if (!ap_rst_n) begin
      exp_wr[k] = 0;
      exp_rd[k] = 0;
      m_n[k]    = 0;
      m_pos[k]  = 0;
    end else begin
      if (xfer) begin
        chk("word_expected", k, 64'(exp_wr[k] != exp_rd[k]), 64'(1));
        if (exp_wr[k] != exp_rd[k]) begin
          chk("out_word", k, 64'(w), 64'(exp_q[k][exp_rd[k] % 64]));
          exp_rd[k]++;
        end
        log_w[k][log_n[k] % 128] = w;
        log_n[k]++;
        if (w.last) last_cnt[k]++;
        fd_exp[k] = w.last;
      end
      if (o_valid[k] && !dma_ready[k]) begin
        hold[k] = 1'b1;
        held[k] = w;
      end
      if (in_valid[k] && s_ready[k]) model_push(k, in_data[k]);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge ap_clk);
      for (int k = 0; k < NDUT; k++) mon_dut(k);
    end
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int t;
    in_data[k]  = b;
    in_valid[k] = 1'b1;
    t = 0;
    @(negedge ap_clk);
    while (!s_ready[k] && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    chk("in_ready", k, 64'(s_ready[k]), 64'(1));
    @(posedge ap_clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while (o_valid[k] && t < 200) begin
      @(posedge ap_clk);
      #1;
      t++;
    end
    chk("drain", k, 64'(o_valid[k]), 64'(0));
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  function automatic l6_word_t mk(input logic [31:0] d, input logic [3:0] kp, input logic l);
    l6_word_t w;
    w.data = d;
    w.keep = kp;
    w.last = l;
    return w;
  endfunction

  initial begin
    int start, f0, acc, k;
    bit sampled, drop_checked;
    logic [7:0] b;

    vecs[0] = '{dut: 0, first: 8'h01, n: 8, n_fd: 1, w0: 32'h04030201, k0: 4'hF, l0: 1'b0,
                w1: 32'h08070605, k1: 4'hF, l1: 1'b1};
    vecs[1] = '{dut: 1, first: 8'hA0, n: 6, n_fd: 1, w0: 32'hA3A2A1A0, k0: 4'hF, l0: 1'b0,
                w1: 32'h0000A5A4, k1: 4'h3, l1: 1'b1};
    vecs[2] = '{dut: 1, first: 8'hB0, n: 6, n_fd: 1, w0: 32'hB3B2B1B0, k0: 4'hF, l0: 1'b0,
                w1: 32'h0000B5B4, k1: 4'h3, l1: 1'b1};
    vecs[3] = '{dut: 2, first: 8'h5A, n: 2, n_fd: 2, w0: 32'h0000005A, k0: 4'h1, l0: 1'b1,
                w1: 32'h0000005B, k1: 4'h1, l1: 1'b1};

    for (int i = 0; i < NDUT; i++) begin
      in_data[i] = 8'h00; in_valid[i] = 1'b0; dma_ready[i] = 1'b1;
      exp_wr[i] = 0; exp_rd[i] = 0; m_n[i] = 0; m_pos[i] = 0; fd_exp[i] = 1'b0;
      hold[i] = 1'b0; held[i] = '0; log_n[i] = 0; last_cnt[i] = 0; fd_cnt[i] = 0;
    end
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state and ready release timing.
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_tvalid", i, 64'(o_valid[i]), 64'(0));
      chk("rst_tdata", i, 64'(o_data[i]), 64'(0));
      chk("rst_tkeep", i, 64'(o_keep[i]), 64'(0));
      chk("rst_tlast", i, 64'(o_last[i]), 64'(0));
      chk("rst_framedone", i, 64'(o_fd[i]), 64'(0));
      chk("rst_tready", i, 64'(s_ready[i]), 64'(0));
    end
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("tready_first_cycle", 0, 64'(s_ready[0]), 64'(0));
    @(negedge ap_clk);
    for (int i = 0; i < NDUT; i++) chk("tready_after_rst", i, 64'(s_ready[i]), 64'(1));
    @(posedge ap_clk);
    #1;

    // Directed table: basic pack, partial final word, frame restart, single-byte frames.
    for (int i = 0; i < 4; i++) begin
      k = vecs[i].dut;
      dma_ready[k] = 1'b1;
      start = log_n[k];
      f0 = fd_cnt[k];
      for (int j = 0; j < vecs[i].n; j++) send(k, vecs[i].first + 8'(j));
      wait_idle(k);
      chk("vec_word_count", k, 64'(log_n[k] - start), 64'(2));
      chk("vec_word0", k, 64'(log_w[k][start % 128]), 64'(mk(vecs[i].w0, vecs[i].k0, vecs[i].l0)));
      chk("vec_word1", k, 64'(log_w[k][(start + 1) % 128]),
          64'(mk(vecs[i].w1, vecs[i].k1, vecs[i].l1)));
      chk("vec_framedone_count", k, 64'(fd_cnt[k] - f0), 64'(vecs[i].n_fd));
    end

    // Back-pressure: 16 bytes offered to the frame-8 instance with the DMA stalled.
    dma_ready[0] = 1'b0;
    start = log_n[0];
    acc = 0;
    drop_checked = 1'b0;
    in_data[0] = 8'h41;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge ap_clk);
      sampled = s_ready[0] && in_valid[0];
      if (acc == 8 && !drop_checked) begin
        chk("ready_drop_after_8", 0, 64'(s_ready[0]), 64'(0));
        drop_checked = 1'b1;
      end
      @(posedge ap_clk);
      #1;
      if (sampled) begin
        acc++;
        in_data[0] = 8'(32'h41 + acc);
      end
    end
    chk("bp_accepted", 0, 64'(acc), 64'(8));
    chk("bp_tready", 0, 64'(s_ready[0]), 64'(0));
    chk("bp_tvalid", 0, 64'(o_valid[0]), 64'(1));
    chk("bp_head", 0, 64'(o_data[0]), 64'(32'h44434241));
    dma_ready[0] = 1'b1;
    for (int c = 0; c < 60 && acc < 16; c++) begin
      @(negedge ap_clk);
      sampled = s_ready[0] && in_valid[0];
      @(posedge ap_clk);
      #1;
      if (sampled) begin
        acc++;
        in_data[0] = 8'(32'h41 + acc);
        if (acc == 16) in_valid[0] = 1'b0;
      end
    end
    in_valid[0] = 1'b0;
    chk("bp_accepted_total", 0, 64'(acc), 64'(16));
    wait_idle(0);
    chk("bp_word_count", 0, 64'(log_n[0] - start), 64'(4));
    for (int j = 0; j < 4; j++) begin
      b = 8'(32'h41 + 4 * j);
      chk("bp_word", 0, 64'(log_w[0][(start + j) % 128]),
          64'(mk({b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'hF, 1'(j % 2))));
    end

    // Random valid/ready: 10 frames per instance.
    for (int kk = 0; kk < NDUT; kk++) begin
      start = last_cnt[kk];
      f0 = fd_cnt[kk];
      rnd_done = 1'b0;
      fork
        begin
          for (int j = 0; j < 10 * fl(kk); j++) begin
            while ($urandom_range(1, 0) == 1) begin
              @(posedge ap_clk);
              #1;
            end
            send(kk, 8'($urandom));
          end
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            @(posedge ap_clk);
            #1;
            dma_ready[kk] = 1'($urandom_range(1, 0));
          end
        end
      join
      dma_ready[kk] = 1'b1;
      wait_idle(kk);
      chk("rnd_tlast_count", kk, 64'(last_cnt[kk] - start), 64'(10));
      chk("rnd_framedone_count", kk, 64'(fd_cnt[kk] - f0), 64'(10));
    end

    // Reset mid-frame: one word buffered plus a partial lane, then a fresh frame.
    dma_ready[0] = 1'b0;
    for (int j = 0; j < 5; j++) send(0, 8'(32'h21 + j));
    chk("pre_rst_tvalid", 0, 64'(o_valid[0]), 64'(1));
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("midrst_tvalid", 0, 64'(o_valid[0]), 64'(0));
    chk("midrst_tready", 0, 64'(s_ready[0]), 64'(0));
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    dma_ready[0] = 1'b1;
    start = log_n[0];
    for (int j = 0; j < 8; j++) send(0, 8'(32'h11 + j));
    wait_idle(0);
    chk("postrst_word_count", 0, 64'(log_n[0] - start), 64'(2));
    chk("postrst_word0", 0, 64'(log_w[0][start % 128]), 64'(mk(32'h14131211, 4'hF, 1'b0)));
    chk("postrst_word1", 0, 64'(log_w[0][(start + 1) % 128]),
        64'(mk(32'h18171615, 4'hF, 1'b1)));

    // Simultaneous push and pop with one word buffered.
    dma_ready[0] = 1'b0;
    for (int j = 0; j < 7; j++) send(0, 8'(32'h31 + j));
    in_data[0] = 8'h38;
    in_valid[0] = 1'b1;
    dma_ready[0] = 1'b1;
    @(negedge ap_clk);
    chk("pp_tready", 0, 64'(s_ready[0]), 64'(1));
    chk("pp_old_head", 0, 64'(o_data[0]), 64'(32'h34333231));
    @(posedge ap_clk);
    #1 in_valid[0] = 1'b0;
    @(negedge ap_clk);
    chk("pp_tvalid", 0, 64'(o_valid[0]), 64'(1));
    chk("pp_new_head", 0, 64'(o_data[0]), 64'(32'h38373635));
    chk("pp_new_last", 0, 64'(o_last[0]), 64'(1));
    @(negedge ap_clk);
    chk("pp_single_entry", 0, 64'(o_valid[0]), 64'(0));
    repeat (3) @(posedge ap_clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
